// File: rtl/universal_register_d.sv
// Mode-selectable WIDTH-bit register: load, shift, rotate, increment/decrement, with carry and zero flags.
// Optional registered parity output enabled by defining UREG_PARITY_EN.
module universal_register_d #(
  parameter int unsigned          WIDTH       = 8,
  parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
  input  logic             Ck,
  input  logic             ClrN,
  input  logic             En,
  input  logic [2:0]       Mode,
  input  logic [WIDTH-1:0] D,
  input  logic             SI,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QN,
  output logic             Carry,
  output logic             Zero
`ifdef UREG_PARITY_EN
  ,
  output logic             Parity
`endif
);

  localparam int unsigned SUM_W = WIDTH + 1;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_INC  = 3'b110;
  localparam logic [2:0] MODE_DEC  = 3'b111;

  logic [WIDTH-1:0] q_next;
  logic             carry_next;
  logic [SUM_W-1:0] inc_sum;

  // Next-state selection; an unknown Mode poisons Q so illegal stimulus is visible.
  always_comb begin
    q_next     = Q;
    carry_next = Carry;
    inc_sum    = {1'b0, Q} + SUM_W'(1);
    if (En) begin
      case (Mode)
        MODE_HOLD: begin
          q_next     = Q;
          carry_next = Carry;
        end
        MODE_LOAD: begin
          q_next     = D;
          carry_next = 1'b0;
        end
        MODE_SHL: begin
          q_next     = {Q[WIDTH-2:0], SI};
          carry_next = Q[WIDTH-1];
        end
        MODE_SHR: begin
          q_next     = {SI, Q[WIDTH-1:1]};
          carry_next = Q[0];
        end
        MODE_ROL: begin
          q_next     = {Q[WIDTH-2:0], Q[WIDTH-1]};
          carry_next = Q[WIDTH-1];
        end
        MODE_ROR: begin
          q_next     = {Q[0], Q[WIDTH-1:1]};
          carry_next = Q[0];
        end
        MODE_INC: begin
          q_next     = inc_sum[WIDTH-1:0];
          carry_next = inc_sum[WIDTH];
        end
        MODE_DEC: begin
          q_next     = Q - WIDTH'(1);
          carry_next = (Q == '0);
        end
        default: begin
          q_next     = 'x;
          carry_next = 1'bx;
        end
      endcase
    end
  end

  always_ff @(posedge Ck or negedge ClrN) begin
    if (!ClrN) begin
      Q     <= RESET_VALUE;
      Carry <= 1'b0;
    end else begin
      Q     <= q_next;
      Carry <= carry_next;
    end
  end

`ifdef UREG_PARITY_EN
  // Loaded from the next Q so it never lags the register contents.
  always_ff @(posedge Ck or negedge ClrN) begin
    if (!ClrN) begin
      Parity <= ^RESET_VALUE;
    end else begin
      Parity <= ^q_next;
    end
  end
`endif

  assign QN   = ~Q;
  assign Zero = (Q == '0);

endmodule

// File: tb/tb_universal_register_d.sv
// Self-checking bench for universal_register_d (WIDTH=8, RESET_VALUE=0) against an arithmetic model.
module tb_universal_register_d;

  logic       Ck;
  logic       ClrN;
  logic       En;
  logic [2:0] Mode;
  logic [7:0] D;
  logic       SI;
  logic [7:0] Q;
  logic [7:0] QN;
  logic       Carry;
  logic       Zero;
`ifdef UREG_PARITY_EN
  logic       Parity;
`endif

  int errors = 0;
  int checks = 0;
  bit started = 0;

  int unsigned m_q = 0;
  bit          m_c = 0;

  universal_register_d #(.WIDTH(8), .RESET_VALUE(8'h00)) dut (
    .Ck(Ck), .ClrN(ClrN), .En(En), .Mode(Mode), .D(D), .SI(SI),
    .Q(Q), .QN(QN), .Carry(Carry), .Zero(Zero)
`ifdef UREG_PARITY_EN
    , .Parity(Parity)
`endif
  );

  initial Ck = 1'b0;
  always #5 Ck = ~Ck;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: register contents as an integer 0..255, operations as plain arithmetic.
  always @(posedge Ck or negedge ClrN) begin
    if (!ClrN) begin
      m_q <= 0;
      m_c <= 0;
    end else if (En) begin
      case (Mode)
        3'd0: ;
        3'd1: begin m_q <= D;                            m_c <= 0;            end
        3'd2: begin m_q <= (m_q * 2 + SI) % 256;         m_c <= (m_q >= 128); end
        3'd3: begin m_q <= m_q / 2 + SI * 128;           m_c <= (m_q % 2);    end
        3'd4: begin m_q <= (m_q * 2) % 256 + m_q / 128;  m_c <= (m_q >= 128); end
        3'd5: begin m_q <= m_q / 2 + (m_q % 2) * 128;    m_c <= (m_q % 2);    end
        3'd6: begin m_q <= (m_q + 1) % 256;              m_c <= ((m_q + 1) / 256); end
        default: begin m_q <= (m_q + 255) % 256;         m_c <= (m_q == 0);   end
      endcase
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge Ck) begin
    if (started) begin
      chk("model_q", 64'(Q), 64'(m_q));
      chk("model_qn", 64'(QN), 64'(8'(~m_q)));
      chk("model_carry", 64'(Carry), 64'(m_c));
      chk("model_zero", 64'(Zero), 64'(m_q == 0));
`ifdef UREG_PARITY_EN
      chk("model_parity", 64'(Parity), 64'($countones(m_q) % 2));
`endif
    end
  end

  task automatic op(input logic en, input logic [2:0] mode, input logic [7:0] d, input logic si);
    @(negedge Ck);
    #1;
    En = en; Mode = mode; D = d; SI = si;
    @(posedge Ck);
    #1;
  endtask

  initial begin
    ClrN = 1'b1; En = 1'b0; Mode = 3'd0; D = 8'h00; SI = 1'b0;
    #1 ClrN = 1'b0;
    started = 1;
    // Reset held with active random stimulus, including En=1 on the edge.
    for (int i = 0; i < 4; i++) op(1'b1, 3'($urandom_range(1, 7)), 8'($urandom), 1'($urandom));
    chk("rst_q", 64'(Q), 64'h00);
    chk("rst_qn", 64'(QN), 64'hFF);
    chk("rst_carry", 64'(Carry), 64'h0);
    chk("rst_zero", 64'(Zero), 64'h1);
    @(negedge Ck); #1 ClrN = 1'b1;

    op(1'b1, 3'd1, 8'hA5, 1'b0);
    chk("load_q", 64'(Q), 64'hA5);
    chk("load_qn", 64'(QN), 64'h5A);
    chk("load_carry", 64'(Carry), 64'h0);
    for (int i = 0; i < 3; i++) op(1'b0, 3'd1, 8'h00, 1'b0);
    chk("en0_hold", 64'(Q), 64'hA5);

    op(1'b1, 3'd1, 8'h81, 1'b0);
    op(1'b1, 3'd2, 8'h00, 1'b0);
    chk("shl_q", 64'(Q), 64'h02);
    chk("shl_carry", 64'(Carry), 64'h1);
    op(1'b1, 3'd3, 8'h00, 1'b1);
    chk("shr_q", 64'(Q), 64'h81);
    chk("shr_carry", 64'(Carry), 64'h0);

    op(1'b1, 3'd4, 8'h00, 1'b0);
    chk("rol_q", 64'(Q), 64'h03);
    chk("rol_carry", 64'(Carry), 64'h1);
    op(1'b1, 3'd1, 8'h81, 1'b0);
    op(1'b1, 3'd5, 8'h00, 1'b0);
    chk("ror_q", 64'(Q), 64'hC0);
    chk("ror_carry", 64'(Carry), 64'h1);
    op(1'b1, 3'd0, 8'h55, 1'b1);
    chk("hold_q", 64'(Q), 64'hC0);
    chk("hold_carry", 64'(Carry), 64'h1);

    op(1'b1, 3'd1, 8'hFE, 1'b0);
    op(1'b1, 3'd6, 8'h00, 1'b0);
    chk("inc1_q", 64'(Q), 64'hFF);
    chk("inc1_carry", 64'(Carry), 64'h0);
    op(1'b1, 3'd6, 8'h00, 1'b0);
    chk("inc2_q", 64'(Q), 64'h00);
    chk("inc2_carry", 64'(Carry), 64'h1);
    chk("inc2_zero", 64'(Zero), 64'h1);
    op(1'b1, 3'd7, 8'h00, 1'b0);
    chk("dec_q", 64'(Q), 64'hFF);
    chk("dec_carry", 64'(Carry), 64'h1);
    op(1'b1, 3'd7, 8'h00, 1'b0);
    chk("dec2_q", 64'(Q), 64'hFE);
    chk("dec2_carry", 64'(Carry), 64'h0);

`ifdef UREG_PARITY_EN
    op(1'b1, 3'd1, 8'h07, 1'b0);
    chk("par_load07", 64'(Parity), 64'h1);
    op(1'b1, 3'd6, 8'h00, 1'b0);
    chk("par_inc_q", 64'(Q), 64'h08);
    chk("par_inc", 64'(Parity), 64'h1);
    op(1'b1, 3'd1, 8'h03, 1'b0);
    chk("par_load03", 64'(Parity), 64'h0);
`endif

    // Reset pulse between edges clears without a clock edge.
    op(1'b1, 3'd1, 8'h5A, 1'b0);
    op(1'b1, 3'd2, 8'h00, 1'b1);
    @(negedge Ck); #1 ClrN = 1'b0;
    #1;
    chk("async_q", 64'(Q), 64'h00);
    chk("async_qn", 64'(QN), 64'hFF);
    chk("async_carry", 64'(Carry), 64'h0);
    chk("async_zero", 64'(Zero), 64'h1);
    #1 ClrN = 1'b1;

    // Back-to-back random legal operations checked by the model.
    for (int i = 0; i < 60; i++)
      op(1'(($urandom % 4) != 0), 3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom));

    @(negedge Ck); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
